// File: rtl/ssio_sdr_tx_arb.sv
// ssio_sdr_tx_arb: schedules PORTS stream requesters onto one SDR link.
// Each granted packet is framed as idle -> preamble -> data -> gap.
//
// Ports:
//   clk, rst        link clock, synchronous active-high reset
//   s_tdata/tvalid/ per-port stream inputs (port p at [p*WIDTH +: WIDTH])
//   s_tlast
//   s_tready        per-port ready, one-hot or zero, from state/grant only
//   output_d        registered link word (feeds SDR output input_d)
//   output_ctl      registered frame-valid flag (preamble and data)
//   output_err      registered underflow flag
//   grant           current or last granted port
//   busy            high whenever the scheduler is not idle
//
// Build option: define SSIO_TX_ARB_RR_EN for round-robin arbitration;
// without it the lowest-index requester wins.

module ssio_sdr_tx_arb #(
   parameter int WIDTH = 4,
   parameter int PORTS = 2,
   parameter int PREAMBLE_CYCLES = 2,
   parameter int IFG_CYCLES = 3,
   parameter logic [WIDTH-1:0] IDLE_PATTERN = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] PREAMBLE_PATTERN = {WIDTH/2{2'b01}},
   localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PORTS*WIDTH-1:0] s_tdata,
   input  logic [PORTS-1:0]       s_tvalid,
   input  logic [PORTS-1:0]       s_tlast,
   output logic [PORTS-1:0]       s_tready,
   output logic [WIDTH-1:0]       output_d,
   output logic                   output_ctl,
   output logic                   output_err,
   output logic [GW-1:0]          grant,
   output logic                   busy
);

   if (PORTS < 1 || PORTS > 8) begin : g_bad_ports
      $error("PORTS must be 1..8");
   end
   if (PREAMBLE_CYCLES < 1 || PREAMBLE_CYCLES > 15) begin : g_bad_pre
      $error("PREAMBLE_CYCLES must be 1..15");
   end
   if (IFG_CYCLES < 1 || IFG_CYCLES > 15) begin : g_bad_ifg
      $error("IFG_CYCLES must be 1..15");
   end

   localparam logic [3:0] PRE_LOAD = 4'(PREAMBLE_CYCLES - 1);
   localparam logic [3:0] IFG_LOAD = 4'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_IFG
   } state_t;

   state_t state;
   logic [3:0] cnt;
   logic [GW-1:0] sel;
   logic req_any;
   logic g_valid;
   logic g_last;
   logic [WIDTH-1:0] g_data;

   assign req_any = |s_tvalid;
   assign g_valid = s_tvalid[grant];
   assign g_last  = s_tlast[grant];
   assign g_data  = s_tdata[int'(grant)*WIDTH +: WIDTH];
   assign busy    = (state != ST_IDLE);

`ifdef SSIO_TX_ARB_RR_EN
   logic [GW-1:0] ptr;

   // Walk backwards so the port closest after ptr is the last write.
   always_comb begin
      sel = '0;
      for (int i = PORTS; i >= 1; i--) begin
         if (s_tvalid[(int'(ptr) + i) % PORTS])
            sel = GW'((int'(ptr) + i) % PORTS);
      end
   end

   // Reset to the last port so port 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= GW'(PORTS - 1);
      else if (state == ST_IDLE && req_any)
         ptr <= sel;
   end
`else
   always_comb begin
      sel = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (s_tvalid[i])
            sel = GW'(i);
      end
   end
`endif

   always_comb begin
      s_tready = '0;
      if (state == ST_DATA)
         s_tready[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         grant      <= '0;
         output_d   <= IDLE_PATTERN;
         output_ctl <= 1'b0;
         output_err <= 1'b0;
      end else begin
         output_d   <= IDLE_PATTERN;
         output_ctl <= 1'b0;
         output_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_any) begin
                  grant <= sel;
                  cnt   <= PRE_LOAD;
                  state <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               output_d   <= PREAMBLE_PATTERN;
               output_ctl <= 1'b1;
               if (cnt == 4'd0)
                  state <= ST_DATA;
               else
                  cnt <= cnt - 4'd1;
            end
            ST_DATA: begin
               output_ctl <= 1'b1;
               if (g_valid) begin
                  output_d <= g_data;
                  if (g_last) begin
                     cnt   <= IFG_LOAD;
                     state <= ST_IFG;
                  end
               end else begin
                  // Underflow keeps the frame open and flags the word.
                  output_err <= 1'b1;
               end
            end
            ST_IFG: begin
               if (cnt == 4'd0)
                  state <= ST_IDLE;
               else
                  cnt <= cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ssio_sdr_tx_arb.sv
// tb_ssio_sdr_tx_arb: vector table, directed sequences and a random
// run against a frame-timeline reference model.

module tb_ssio_sdr_tx_arb;

   localparam int W = 4;
   localparam int P = 2;
   localparam int PRE = 2;
   localparam int IFG = 3;

   logic clk = 1'b0;
   logic rst;
   logic [P*W-1:0] s_tdata;
   logic [P-1:0] s_tvalid;
   logic [P-1:0] s_tlast;
   logic [P-1:0] s_tready;
   logic [W-1:0] output_d;
   logic output_ctl;
   logic output_err;
   logic [0:0] grant;
   logic busy;

   always #5 clk = ~clk;

   ssio_sdr_tx_arb #(
      .WIDTH(W),
      .PORTS(P),
      .PREAMBLE_CYCLES(PRE),
      .IFG_CYCLES(IFG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_tdata(s_tdata),
      .s_tvalid(s_tvalid),
      .s_tlast(s_tlast),
      .s_tready(s_tready),
      .output_d(output_d),
      .output_ctl(output_ctl),
      .output_err(output_err),
      .grant(grant),
      .busy(busy)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic r;
      logic [1:0] v;
      logic [7:0] d;
      logic [1:0] l;
      logic [1:0] rdy;
      logic [3:0] q;
      logic ctl;
      logic err;
      logic bsy;
      logic g;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [1:0] v,
                               input logic [7:0] d, input logic [1:0] l,
                               input logic [1:0] rdy, input logic [3:0] q,
                               input logic ctl, err, bsy, g);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.l = l; t.rdy = rdy;
      t.q = q; t.ctl = ctl; t.err = err; t.bsy = bsy; t.g = g;
      tbl.push_back(t);
   endfunction

   task automatic apply(input vec_t t, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      rst = t.r; s_tvalid = t.v; s_tdata = t.d; s_tlast = t.l;
      #1 chk({tag, " ready"}, 32'(s_tready), 32'(t.rdy));
      @(posedge clk); #1;
      chk({tag, " d"}, 32'(output_d), 32'(t.q));
      chk({tag, " ctl"}, 32'(output_ctl), 32'(t.ctl));
      chk({tag, " err"}, 32'(output_err), 32'(t.err));
      chk({tag, " busy"}, 32'(busy), 32'(t.bsy));
      chk({tag, " grant"}, 32'(grant), 32'(t.g));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      @(posedge clk); #1;
   endtask

   function automatic int arb(input logic [1:0] v, input int lastg);
`ifdef SSIO_TX_ARB_RR_EN
      for (int k = 1; k <= P; k++)
         if (v[(lastg + k) % P]) return (lastg + k) % P;
`else
      for (int k = 0; k < P; k++)
         if (v[k]) return k;
`endif
      return 0;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g[4];
      int got_g[$];
      int beats[P];
      logic [1:0] xfer;
      logic prev_b;
      logic prev_c;
      int ones, zeros, runs, gaps;
      int e, start, free_at, win, lastg, rem[P];
      bit inf;
      logic [1:0] rv, rl, erdy;
      logic [7:0] rd;
      logic rr;
      logic [3:0] eq;
      logic ectl, eerr, ebsy;

      rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      @(posedge clk); #1;

      // reset hold and idle
      add(1,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,0);
      add(1,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,0);
      for (int i = 0; i < 3; i++)
         add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,0);
      // single 3-beat frame on port 1
      add(0,2'b10,8'hA0,2'b00,2'b00,4'h0,0,0,1,1);
      add(0,2'b10,8'hA0,2'b00,2'b00,4'h5,1,0,1,1);
      add(0,2'b10,8'hA0,2'b00,2'b00,4'h5,1,0,1,1);
      add(0,2'b10,8'hA0,2'b00,2'b10,4'hA,1,0,1,1);
      add(0,2'b10,8'hB0,2'b00,2'b10,4'hB,1,0,1,1);
      add(0,2'b10,8'hC0,2'b10,2'b10,4'hC,1,0,1,1);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,1,1);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,1,1);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,1);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,1);
      // underflow on port 0
      add(0,2'b01,8'h01,2'b00,2'b00,4'h0,0,0,1,0);
      add(0,2'b01,8'h01,2'b00,2'b00,4'h5,1,0,1,0);
      add(0,2'b01,8'h01,2'b00,2'b00,4'h5,1,0,1,0);
      add(0,2'b01,8'h01,2'b00,2'b01,4'h1,1,0,1,0);
      add(0,2'b00,8'h00,2'b00,2'b01,4'h0,1,1,1,0);
      add(0,2'b00,8'h00,2'b00,2'b01,4'h0,1,1,1,0);
      add(0,2'b01,8'h02,2'b01,2'b01,4'h2,1,0,1,0);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,1,0);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,1,0);
      add(0,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,0);
      // reset during beat 2, then port 1 restarts
      add(0,2'b01,8'h03,2'b00,2'b00,4'h0,0,0,1,0);
      add(0,2'b01,8'h03,2'b00,2'b00,4'h5,1,0,1,0);
      add(0,2'b01,8'h03,2'b00,2'b00,4'h5,1,0,1,0);
      add(0,2'b01,8'h03,2'b00,2'b01,4'h3,1,0,1,0);
      add(1,2'b01,8'h04,2'b00,2'b01,4'h0,0,0,0,0);
      add(0,2'b10,8'h70,2'b00,2'b00,4'h0,0,0,1,1);
      add(0,2'b10,8'h70,2'b00,2'b00,4'h5,1,0,1,1);
      add(1,2'b00,8'h00,2'b00,2'b00,4'h0,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i);

      // arbitration with both ports streaming 2-beat frames
`ifdef SSIO_TX_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      do_reset();
      beats = '{0, 0};
      prev_b = 1'b0;
      for (int c = 0; c < 200 && got_g.size() < 4; c++) begin
         @(negedge clk);
         rst = 1'b0;
         s_tvalid = 2'b11;
         s_tdata = {4'(8 + beats[1]), 4'(beats[0])};
         s_tlast = {beats[1] == 1, beats[0] == 1};
         #1 xfer = s_tready & s_tvalid;
         @(posedge clk); #1;
         for (int p = 0; p < P; p++)
            if (xfer[p]) beats[p] = (beats[p] == 1) ? 0 : 1;
         if (busy && !prev_b) got_g.push_back(int'(grant));
         prev_b = busy;
      end
      chk("arb frames", 32'(got_g.size()), 32'd4);
      for (int k = 0; k < got_g.size() && k < 4; k++)
         chk($sformatf("arb grant%0d", k), 32'(got_g[k]), 32'(exp_g[k]));

      // back-to-back 1-beat frames on port 0
      do_reset();
      prev_c = 1'b0; ones = 0; zeros = 0; runs = 0; gaps = 0;
      for (int c = 0; c < 100 && gaps < 3; c++) begin
         @(negedge clk);
         rst = 1'b0;
         s_tvalid = 2'b01;
         s_tlast = 2'b01;
         s_tdata = 8'($urandom);
         @(posedge clk); #1;
         if (output_ctl) begin
            if (!prev_c) begin
               if (runs > 0) begin
                  chk("b2b gap", 32'(zeros), 32'(IFG + 1));
                  gaps++;
               end
               runs++;
               ones = 0;
            end
            ones++;
         end else begin
            if (prev_c) begin
               chk("b2b run", 32'(ones), 32'(PRE + 1));
               zeros = 0;
            end
            zeros++;
         end
         prev_c = output_ctl;
      end
      chk("b2b gaps", 32'(gaps), 32'd3);

      // random traffic against a frame-timeline model
      do_reset();
      e = 0; start = 0; free_at = 0; inf = 0; win = 0; lastg = P - 1;
      for (int p = 0; p < P; p++) rem[p] = $urandom_range(1, 4);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rr = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < P; p++) begin
            rv[p] = ($urandom_range(0, 3) != 0);
            rl[p] = (rem[p] == 1);
         end
         rd = 8'($urandom);
         rst = rr; s_tvalid = rv; s_tdata = rd; s_tlast = rl;
         erdy = (inf && e > start + PRE) ? 2'(1 << win) : 2'b00;
         #1 chk("rnd ready", 32'(s_tready), 32'(erdy));
         eq = 4'h0; ectl = 0; eerr = 0; ebsy = 0;
         if (rr) begin
            inf = 0; free_at = e + 1; win = 0; lastg = P - 1;
            for (int p = 0; p < P; p++) rem[p] = $urandom_range(1, 4);
         end else if (!inf) begin
            if (e >= free_at && rv != 2'b00) begin
               win = arb(rv, lastg);
               lastg = win;
               start = e;
               inf = 1;
               ebsy = 1;
            end else begin
               ebsy = (e < free_at - 1);
            end
         end else if (e <= start + PRE) begin
            eq = 4'h5; ectl = 1; ebsy = 1;
         end else begin
            ectl = 1; ebsy = 1;
            if (rv[win]) begin
               eq = rd[win*W +: W];
               if (rl[win]) begin
                  inf = 0;
                  free_at = e + IFG + 1;
               end
               rem[win]--;
               if (rem[win] == 0) rem[win] = $urandom_range(1, 4);
            end else begin
               eerr = 1;
            end
         end
         @(posedge clk); #1;
         chk("rnd d", 32'(output_d), 32'(eq));
         chk("rnd ctl", 32'(output_ctl), 32'(ectl));
         chk("rnd err", 32'(output_err), 32'(eerr));
         chk("rnd busy", 32'(busy), 32'(ebsy));
         chk("rnd grant", 32'(grant), 32'(win));
         e++;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
